// File: rtl/cmp_arbiter_pkg.sv
// Shared constants for the comparator arbiter: compare func codes
// and response-register state encodings.
package cmp_arbiter_pkg;

    localparam logic [2:0] FN_BEQ  = 3'b000;
    localparam logic [2:0] FN_BNE  = 3'b001;
    localparam logic [2:0] FN_SLT  = 3'b010;
    localparam logic [2:0] FN_SLTU = 3'b011;
    localparam logic [2:0] FN_BLT  = 3'b100;
    localparam logic [2:0] FN_BGE  = 3'b101;
    localparam logic [2:0] FN_BLTU = 3'b110;
    localparam logic [2:0] FN_BGEU = 3'b111;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

endpackage

// File: rtl/Comparator.sv
// Single shared compare unit: equality, signed and unsigned ordering
// selected by a 3-bit func code.
module Comparator
    import cmp_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             comp
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (a == b);
    assign lt_s = ($signed(a) < $signed(b));
    assign lt_u = (a < b);

    always_comb begin
        comp = 1'b0;
        unique case (func)
            FN_BEQ:  comp = eq;
            FN_BNE:  comp = ~eq;
            FN_SLT:  comp = lt_s;
            FN_SLTU: comp = lt_u;
            FN_BLT:  comp = lt_s;
            FN_BGE:  comp = ~lt_s;
            FN_BLTU: comp = lt_u;
            FN_BGEU: comp = ~lt_u;
        endcase
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one Comparator between the branch unit
// (port 0) and the ALU set-less-than path (port 1).
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_func,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_func,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_comp,
    output logic             resp_id,
    output logic             busy
);

    logic state_q, state_d;
    logic resp_comp_q, resp_comp_d;
    logic resp_id_q, resp_id_d;
    logic rr_last_q, rr_last_d;

    logic             can_accept;
    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic             sel;
    logic [2:0]       cmp_func;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_out;

    // Each grant is derived from both valids directly, never from the
    // other port's ready, so there is no combinational ready-ready loop.
    always_comb begin
        can_accept = (state_q == ST_EMPTY) | resp_ready;
        gnt0 = can_accept & req0_valid & (~req1_valid | rr_last_q);
        gnt1 = can_accept & req1_valid & (~req0_valid | ~rr_last_q);
        accept = gnt0 | gnt1;
        sel = gnt1 | (~gnt0 & ~rr_last_q);
    end

    always_comb begin
        cmp_func = sel ? req1_func : req0_func;
        cmp_a    = sel ? req1_a    : req0_a;
        cmp_b    = sel ? req1_b    : req0_b;
    end

    Comparator #(.WIDTH(WIDTH)) u_cmp (
        .func (cmp_func),
        .a    (cmp_a),
        .b    (cmp_b),
        .comp (cmp_out)
    );

    always_comb begin
        state_d     = state_q;
        resp_comp_d = resp_comp_q;
        resp_id_d   = resp_id_q;
        rr_last_d   = rr_last_q;
        if (accept) begin
            state_d     = ST_FULL;
            resp_comp_d = cmp_out;
            resp_id_d   = sel;
            rr_last_d   = sel;
        end else if (resp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            resp_comp_q <= 1'b0;
            resp_id_q   <= 1'b0;
            rr_last_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            resp_comp_q <= resp_comp_d;
            resp_id_q   <= resp_id_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign resp_valid = (state_q == ST_FULL);
    assign busy       = (state_q == ST_FULL);
    assign resp_comp  = resp_comp_q;
    assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed vector table, async
// reset case, alternation run and randomized model comparison.
module tb_cmp_arbiter;
    import cmp_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [2:0]  req0_func;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [2:0]  req1_func;
    logic [31:0] req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_comp, resp_id, busy;

    always #5 clk = ~clk;

    cmp_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_func  (req0_func),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_func  (req1_func),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_comp  (resp_comp),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    typedef struct packed {
        logic        v0;
        logic [2:0]  f0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic        v1;
        logic [2:0]  f1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        rr;
        logic        er0;
        logic        er1;
        logic        ev;
        logic        ec;
        logic        eid;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit m_full;
    bit m_last;
    bit m_comp;
    bit m_id;

    function automatic vec_t mk(
        bit v0, logic [2:0] f0, logic [31:0] a0, logic [31:0] b0,
        bit v1, logic [2:0] f1, logic [31:0] a1, logic [31:0] b1,
        bit rr, bit er0, bit er1, bit ev, bit ec, bit eid);
        vec_t v;
        v.v0 = v0; v.f0 = f0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.f1 = f1; v.a1 = a1; v.b1 = b1;
        v.rr = rr; v.er0 = er0; v.er1 = er1;
        v.ev = ev; v.ec = ec; v.eid = eid;
        return v;
    endfunction

    function automatic bit ref_cmp(logic [2:0] f, logic [31:0] a,
                                   logic [31:0] b);
        longint sa, sb;
        longint ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            FN_BEQ:  return ua == ub;
            FN_BNE:  return ua != ub;
            FN_BLT:  return sa < sb;
            FN_SLT:  return sa < sb;
            FN_BGE:  return sa >= sb;
            FN_BLTU: return ua < ub;
            FN_SLTU: return ua < ub;
            default: return ua >= ub;
        endcase
    endfunction

    task automatic chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic drive(vec_t v);
        req0_valid = v.v0; req0_func = v.f0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_func = v.f1; req1_a = v.a1; req1_b = v.b1;
        resp_ready = v.rr;
    endtask

    task automatic idle();
        req0_valid = 0; req0_func = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_func = 0; req1_a = 0; req1_b = 0;
        resp_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_full = 0; m_last = 1; m_comp = 0; m_id = 0;
    endtask

    // Called at posedge+1: drive, check readies, clock, check response.
    task automatic apply_vec(vec_t v, int idx);
        drive(v);
        #1;
        chk($sformatf("vec%0d req0_ready", idx), req0_ready, v.er0);
        chk($sformatf("vec%0d req1_ready", idx), req1_ready, v.er1);
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d resp_valid", idx), resp_valid, v.ev);
        chk($sformatf("vec%0d busy", idx), busy, v.ev);
        chk($sformatf("vec%0d resp_comp", idx), resp_comp, v.ec);
        chk($sformatf("vec%0d resp_id", idx), resp_id, v.eid);
    endtask

    // Model step: one cycle, checks both readies and the response.
    task automatic model_cycle(vec_t v, string tag);
        bit can, both, g0, g1;
        drive(v);
        can  = !m_full || v.rr;
        both = v.v0 && v.v1;
        g0 = 0; g1 = 0;
        if (can) begin
            if (both) begin
                g0 = (m_last == 1);
                g1 = (m_last == 0);
            end else begin
                g0 = v.v0;
                g1 = v.v1;
            end
        end
        #1;
        chk({tag, " req0_ready"}, req0_ready, g0);
        chk({tag, " req1_ready"}, req1_ready, g1);
        @(posedge clk);
        if (g0 || g1) begin
            m_id   = g1;
            m_comp = g1 ? ref_cmp(v.f1, v.a1, v.b1)
                        : ref_cmp(v.f0, v.a0, v.b0);
            m_last = g1;
            m_full = 1;
        end else if (v.rr) begin
            m_full = 0;
        end
        #1;
        chk({tag, " resp_valid"}, resp_valid, m_full);
        chk({tag, " busy"}, busy, m_full);
        chk({tag, " resp_comp"}, resp_comp, m_comp);
        chk({tag, " resp_id"}, resp_id, m_id);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [7:0] sweep_exp;
        vec_t v;
        bit prev_id;
        int t;

        sweep_exp = 8'b0;
        do_reset();
        chk("reset resp_valid", resp_valid, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset resp_comp", resp_comp, 1'b0);
        chk("reset resp_id", resp_id, 1'b0);

        // tie, arbitration, backpressure, single requester, idle drain
        vecs.push_back(mk(1, FN_BLT, 32'hFFFF_FFFF, 1, 1, FN_BLTU,
                          32'hFFFF_FFFF, 1, 1, 1, 0, 1, 1, 0));
        vecs.push_back(mk(1, FN_BLT, 32'hFFFF_FFFF, 1, 1, FN_BLTU,
                          32'hFFFF_FFFF, 1, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(1, FN_BLT, 32'hFFFF_FFFF, 1, 1, FN_BLTU,
                          32'hFFFF_FFFF, 1, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, FN_BLT, 32'hFFFF_FFFF, 1, 1, FN_BLTU,
                          32'hFFFF_FFFF, 1, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, FN_BLT, 32'hFFFF_FFFF, 1, 1, FN_BLTU,
                          32'hFFFF_FFFF, 1, 1, 1, 0, 1, 1, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0, 0, 1, FN_BNE, 5, 5,
                              1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(1, FN_BEQ, 5, 5, 1, FN_BNE, 5, 5,
                          1, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));

        // func sweep, a = 0x8000_0000, b = 1
        sweep_exp[FN_BEQ]  = 0;
        sweep_exp[FN_BNE]  = 1;
        sweep_exp[FN_SLT]  = 1;
        sweep_exp[FN_SLTU] = 0;
        sweep_exp[FN_BLT]  = 1;
        sweep_exp[FN_BGE]  = 0;
        sweep_exp[FN_BLTU] = 0;
        sweep_exp[FN_BGEU] = 1;
        for (int f = 0; f < 8; f++)
            vecs.push_back(mk(1, f[2:0], 32'h8000_0000, 1, 0, 0, 0, 0,
                              1, 1, 0, 1, sweep_exp[f], 0));

        for (int i = 0; i < vecs.size(); i++)
            apply_vec(vecs[i], i);

        // async reset while FULL, then port 0 must win the first tie
        chk("pre-reset resp_valid", resp_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async rst resp_valid", resp_valid, 1'b0);
        chk("async rst busy", busy, 1'b0);
        chk("async rst resp_comp", resp_comp, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply_vec(mk(1, FN_BNE, 1, 2, 1, FN_BEQ, 1, 2,
                     1, 1, 0, 1, 1, 0), 100);

        // full-throughput alternation
        prev_id = resp_id;
        for (int i = 0; i < 16; i++) begin
            drive(mk(1, 3'($urandom), rnd_op(), rnd_op(),
                     1, 3'($urandom), rnd_op(), rnd_op(),
                     1, 0, 0, 0, 0, 0));
            #1;
            chk("alt one ready", req0_ready ^ req1_ready, 1'b1);
            @(posedge clk);
            #1;
            chk("alt resp_valid", resp_valid, 1'b1);
            chk("alt resp_id", resp_id, ~prev_id);
            prev_id = resp_id;
        end

        // randomized comparison against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            t = $urandom_range(0, 3);
            v = mk($urandom_range(0, 3) != 0, 3'($urandom), rnd_op(),
                   rnd_op(), $urandom_range(0, 3) != 0, 3'($urandom),
                   rnd_op(), rnd_op(), t != 0, 0, 0, 0, 0, 0);
            if ($urandom_range(0, 4) == 0) begin
                v.a0 = v.b0;
                v.a1 = v.b1;
            end
            model_cycle(v, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
